// File: rtl/mem_test_seq_if.sv
// Memory test sequencer bus: control/status handshake plus memory port.
interface mem_test_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] address;
    logic              load;
    logic              enable;
    logic              output_en;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_count;
    logic [ADDR_W-1:0] fail_addr;

    // Sequencer side: drives the memory and reports status
    modport master (
        input  start, mode, data_in,
        output address, load, enable, output_en, data_out,
        output busy, done, pass, err_count, fail_addr
    );

    // Host/memory side
    modport slave (
        output start, mode, data_in,
        input  address, load, enable, output_en, data_out,
        input  busy, done, pass, err_count, fail_addr
    );
endinterface

// File: rtl/mem_test_seq.sv
// Memory test sequencer: writes a pattern to COUNT locations, reads them
// back with a fixed read latency, and counts/locates mismatches.
module mem_test_seq #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned COUNT     = 2,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned STRIDE    = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_test_seq_if.master bus
);

    localparam int unsigned IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COUNT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
    localparam logic [1:0]        LAST_LAT = 2'(RD_LAT);

    // Replicate a byte across the data width (truncating a partial byte)
    function automatic logic [DATA_W-1:0] rep_byte(input logic [7:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(DATA_W); k++) begin
            r[k] = b[3'(k)];
        end
        return r;
    endfunction

    localparam logic [DATA_W-1:0] PAT_5A = rep_byte(8'h5A);
    localparam logic [DATA_W-1:0] PAT_A5 = rep_byte(8'hA5);

    // Pattern for a location; walk is the one-hot 1 << (i mod DATA_W)
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic              odd,
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] walk
    );
        case (m)
            2'd0:    return odd ? PAT_A5 : PAT_5A;
            2'd1:    return DATA_W'(a);
            2'd2:    return walk;
            default: return ~walk;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_lat;
    logic [DATA_W-1:0] r_walk;
    logic [DATA_W-1:0] r_exp;
    logic [ADDR_W-1:0] r_address;
    logic              r_load;
    logic              r_enable;
    logic              r_output_en;
    logic [DATA_W-1:0] r_data_out;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [7:0]        r_err;
    logic [ADDR_W-1:0] r_fail;

    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_next_walk;
    logic [DATA_W-1:0] w_next_pat;
    logic [DATA_W-1:0] w_first_pat;
    logic [DATA_W-1:0] w_start_pat;
    logic              w_last;
    logic              w_mismatch;
    logic [7:0]        w_err_next;

    // Next-location address/pattern and compare result
    assign w_next_addr = r_address + STEP;
    assign w_next_walk = {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
    assign w_next_pat  = pattern(r_mode, ~r_idx[0], w_next_addr, w_next_walk);
    assign w_first_pat = pattern(r_mode, 1'b0, BASE, DATA_W'(1));
    assign w_start_pat = pattern(bus.mode, 1'b0, BASE, DATA_W'(1));
    assign w_last      = (r_idx == LAST_IDX);
    assign w_mismatch  = (bus.data_in != r_exp);
    assign w_err_next  = (w_mismatch && (r_err != 8'hFF)) ? r_err + 8'd1 : r_err;

    // Sequencer FSM with registered memory-port and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'd0;
            r_idx       <= '0;
            r_lat       <= 2'd0;
            r_walk      <= DATA_W'(1);
            r_exp       <= '0;
            r_address   <= '0;
            r_load      <= 1'b0;
            r_enable    <= 1'b0;
            r_output_en <= 1'b0;
            r_data_out  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 8'd0;
            r_fail      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state     <= S_WRITE;
                        r_mode      <= bus.mode;
                        r_idx       <= '0;
                        r_walk      <= DATA_W'(1);
                        r_address   <= BASE;
                        r_data_out  <= w_start_pat;
                        r_load      <= 1'b1;
                        r_enable    <= 1'b1;
                        r_output_en <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err       <= 8'd0;
                        r_fail      <= '0;
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state     <= S_READ;
                        r_idx       <= '0;
                        r_walk      <= DATA_W'(1);
                        r_address   <= BASE;
                        r_exp       <= w_first_pat;
                        r_lat       <= 2'd0;
                        r_load      <= 1'b0;
                        r_output_en <= 1'b1;
                        r_data_out  <= '0;
                    end else begin
                        r_idx      <= r_idx + IDX_W'(1);
                        r_walk     <= w_next_walk;
                        r_address  <= w_next_addr;
                        r_data_out <= w_next_pat;
                    end
                end
                S_READ: begin
                    if (r_lat == LAST_LAT) begin
                        r_err <= w_err_next;
                        if (w_mismatch && (r_err == 8'd0)) begin
                            r_fail <= r_address;
                        end
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_pass      <= (w_err_next == 8'd0);
                            r_enable    <= 1'b0;
                            r_output_en <= 1'b0;
                        end else begin
                            r_idx     <= r_idx + IDX_W'(1);
                            r_walk    <= w_next_walk;
                            r_address <= w_next_addr;
                            r_exp     <= w_next_pat;
                            r_lat     <= 2'd0;
                        end
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.address   = r_address;
    assign bus.load      = r_load;
    assign bus.enable    = r_enable;
    assign bus.output_en = r_output_en;
    assign bus.data_out  = r_data_out;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_addr = r_fail;

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq: several parameterised instances, each with its own
// memory model (latency + injectable faults), checked cycle by cycle.
module tb_mem_test_seq;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned CNT  [N] = '{2, 4, 256, 3, 5};
    localparam int unsigned BASE [N] = '{0, 0, 32'h0100, 32'hFFF0, 32'h1234};
    localparam int unsigned STR  [N] = '{16, 32'h4000, 16, 8, 32'h8000};
    localparam int unsigned LAT  [N] = '{1, 1, 1, 0, 3};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start_v  [N];
    logic [1:0]    mode_v   [N];
    logic          stuck_v  [N];
    logic [AW-1:0] flt_a_v  [N];
    logic [DW-1:0] flt_x_v  [N];

    logic [AW-1:0] addr_v [N];
    logic [AW-1:0] fail_v [N];
    logic [DW-1:0] dout_v [N];
    logic [7:0]    err_v  [N];
    logic          load_v [N];
    logic          en_v   [N];
    logic          oe_v   [N];
    logic          busy_v [N];
    logic          done_v [N];
    logic          pass_v [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned PI = (LAT[g] == 0) ? 0 : LAT[g] - 1;
        mem_test_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        logic [DW-1:0] mem  [0:(1<<AW)-1];
        logic [DW-1:0] pipe [0:3];
        logic [DW-1:0] rd_now;

        mem_test_seq #(
            .DATA_W(DW), .ADDR_W(AW), .COUNT(CNT[g]), .BASE_ADDR(BASE[g]),
            .STRIDE(STR[g]), .RD_LAT(LAT[g])
        ) dut (
            .clk(clk), .reset(rst_n), .bus(bus)
        );

        assign bus.start = start_v[g];
        assign bus.mode  = mode_v[g];
        assign rd_now = stuck_v[g] ? '0 :
                        (mem[bus.address] ^ ((bus.address == flt_a_v[g]) ? flt_x_v[g] : '0));

        // Memory: synchronous write, read data delayed by LAT cycles
        always @(posedge clk) begin
            if (bus.enable && bus.load) mem[bus.address] <= bus.data_out;
            pipe[0] <= rd_now;
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign bus.data_in = (LAT[g] == 0) ? rd_now : pipe[2'(PI)];

        assign addr_v[g] = bus.address;
        assign fail_v[g] = bus.fail_addr;
        assign dout_v[g] = bus.data_out;
        assign err_v[g]  = bus.err_count;
        assign load_v[g] = bus.load;
        assign en_v[g]   = bus.enable;
        assign oe_v[g]   = bus.output_en;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign pass_v[g] = bus.pass;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Reference: address and pattern of location i
    function automatic logic [15:0] a_of(input int k, input int i);
        return 16'(BASE[k] + 32'(i) * STR[k]);
    endfunction

    function automatic logic [15:0] p_of(input int k, input int m, input int i);
        case (m)
            0:       return (i % 2 == 1) ? 16'hA5A5 : 16'h5A5A;
            1:       return a_of(k, i);
            2:       return 16'(32'd1 << (i % 16));
            default: return ~16'(32'd1 << (i % 16));
        endcase
    endfunction

    function automatic logic [63:0] ev(input logic b, input logic d, input logic p,
                                       input logic e, input logic l, input logic o,
                                       input logic [15:0] a, input logic [15:0] dd);
        return {26'b0, b, d, p, e, l, o, a, dd};
    endfunction

    function automatic logic [63:0] obs(input int k);
        return {26'b0, busy_v[k], done_v[k], pass_v[k], en_v[k], load_v[k], oe_v[k],
                addr_v[k], dout_v[k]};
    endfunction

    function automatic logic [63:0] res(input int k);
        return 64'({pass_v[k], err_v[k], fail_v[k]});
    endfunction

    // Reference outcome: write image into a memory map, then read it back
    task automatic model(input int k, input int m, output logic [7:0] e_err,
                         output logic [15:0] e_fail);
        logic [15:0] img [int];
        logic [15:0] a, rd;
        int cnt;
        cnt = 0;
        e_fail = '0;
        for (int i = 0; i < int'(CNT[k]); i++) img[int'(a_of(k, i))] = p_of(k, m, i);
        for (int i = 0; i < int'(CNT[k]); i++) begin
            a  = a_of(k, i);
            rd = stuck_v[k] ? 16'h0 : (img[int'(a)] ^ ((a == flt_a_v[k]) ? flt_x_v[k] : 16'h0));
            if (rd != p_of(k, m, i)) begin
                if (cnt == 0) e_fail = a;
                cnt++;
            end
        end
        e_err = (cnt > 255) ? 8'hFF : 8'(cnt);
    endtask

    // One full run on instance k; optional extra start pulse at cycle glitch
    task automatic run(input int k, input int m, input int glitch);
        int lat, cn, total, i;
        logic [7:0]  e_err;
        logic [15:0] e_fail;
        logic [63:0] e;
        lat   = int'(LAT[k]);
        cn    = int'(CNT[k]);
        total = cn + cn * (lat + 1);
        model(k, m, e_err, e_fail);
        @(negedge clk);
        start_v[k] = 1'b1;
        mode_v[k]  = 2'(m);
        @(negedge clk);
        start_v[k] = 1'b0;
        mode_v[k]  = 2'($urandom);
        for (int c = 1; c <= total; c++) begin
            if (c > 1) @(negedge clk);
            start_v[k] = 1'b0;
            if (c <= cn) begin
                e = ev(1, 0, 0, 1, 1, 0, a_of(k, c - 1), p_of(k, m, c - 1));
            end else begin
                i = (c - cn - 1) / (lat + 1);
                e = ev(1, 0, 0, 1, 0, 1, a_of(k, i), 16'h0);
            end
            check($sformatf("run k%0d m%0d cyc%0d", k, m, c), obs(k), e);
            if (c == glitch) start_v[k] = 1'b1;
        end
        @(negedge clk);
        start_v[k] = 1'b0;
        check($sformatf("done k%0d m%0d", k, m), obs(k),
              ev(0, 1, (e_err == 0), 0, 0, 0, a_of(k, cn - 1), 16'h0));
        check($sformatf("result k%0d m%0d", k, m), res(k), 64'({(e_err == 0), e_err, e_fail}));
    endtask

    initial begin
        int k, m, f, tot;
        rst_n = 1'b0;
        for (int j = 0; j < int'(N); j++) begin
            start_v[j] = 1'b0;
            mode_v[j]  = 2'd0;
            stuck_v[j] = 1'b0;
            flt_a_v[j] = '0;
            flt_x_v[j] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < int'(N); j++) begin
            check($sformatf("reset obs k%0d", j), obs(j), 64'h0);
            check($sformatf("reset res k%0d", j), res(j), 64'h0);
        end
        rst_n = 1'b1;

        // Default build, alternating 5A/A5
        run(0, 0, 0);
        // Address-as-data across the full address range
        run(1, 1, 0);
        // Bit 0 corrupted at 0x0010, walking ones
        flt_a_v[0] = 16'h0010;
        flt_x_v[0] = 16'h0001;
        run(0, 2, 0);
        flt_x_v[0] = '0;
        // Stuck-at-zero memory, 256 locations, walking zeros: counter saturates
        stuck_v[2] = 1'b1;
        run(2, 3, 0);
        stuck_v[2] = 1'b0;
        // Start pulse during WRITE is ignored
        run(0, 0, 1);

        // Reset during READ aborts the run and keeps the memory idle
        @(negedge clk);
        start_v[0] = 1'b1;
        mode_v[0]  = 2'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("abort in read", 64'(oe_v[0]), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort obs", obs(0), 64'h0);
        check("abort res", res(0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("post-abort idle %0d", c), obs(0), 64'h0);
        end
        run(0, 1, 0);

        // Restart straight from DONE, zero and three-cycle read latency
        run(3, 1, 0);
        run(3, 2, 0);
        run(4, 0, 0);
        run(4, 3, 0);

        // Randomised runs with random faults and stray start pulses
        for (int it = 0; it < 24; it++) begin
            k = int'($urandom_range(0, 3));
            if (k == 2) k = 4;
            m = int'($urandom_range(0, 3));
            f = int'($urandom_range(0, 3));
            stuck_v[k] = (f == 3);
            flt_x_v[k] = '0;
            if (f == 1 || f == 2) begin
                flt_a_v[k] = a_of(k, int'($urandom_range(0, CNT[k] - 1)));
                flt_x_v[k] = 16'(32'd1 << $urandom_range(0, 15));
            end
            tot = int'(CNT[k] * (LAT[k] + 2));
            run(k, m, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 1)) : 0);
            stuck_v[k] = 1'b0;
            flt_x_v[k] = '0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
